// File: rtl/axilite_regfile_slave.sv
// AXI-Lite responder backed by a bank of NUM_REGS read/write registers.
// Independent read and write paths, one outstanding transaction each; register bank exposed flat on reg_q.
module axilite_regfile_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS_W = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [NUM_REGS*DATA_WIDTH-1:0] regs_r;
    logic                           rst_done_r;
    logic                           aw_held_r;
    logic                           w_held_r;
    logic [ADDR_WIDTH-1:0]          awaddr_r;
    logic [DATA_WIDTH-1:0]          wdata_r;
    logic [STRB_W-1:0]              wstrb_r;
    logic                           bvalid_r;
    logic [1:0]                     bresp_r;
    logic                           rvalid_r;
    logic [DATA_WIDTH-1:0]          rdata_r;
    logic [1:0]                     rresp_r;

    logic                           awready_s;
    logic                           wready_s;
    logic                           arready_s;
    logic                           aw_hs_s;
    logic                           w_hs_s;
    logic                           ar_hs_s;
    logic                           commit_s;
    logic [ADDR_WIDTH-1:0]          wr_idx_s;
    logic [ADDR_WIDTH-1:0]          rd_idx_s;
    logic                           wr_ok_s;
    logic                           rd_ok_s;
    logic [DATA_WIDTH-1:0]          rd_data_s;

    function automatic logic [ADDR_WIDTH-1:0] reg_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr >> OFFS_W;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

    // Readies, handshakes and address decode; readies depend only on registered state.
    always_comb begin
        awready_s = rst_done_r & ~aw_held_r & ~bvalid_r;
        wready_s  = rst_done_r & ~w_held_r & ~bvalid_r;
        arready_s = rst_done_r & ~rvalid_r;
        aw_hs_s   = s_awvalid & awready_s;
        w_hs_s    = s_wvalid & wready_s;
        ar_hs_s   = s_arvalid & arready_s;
        commit_s  = aw_held_r & w_held_r;
        wr_idx_s  = reg_index(awaddr_r);
        rd_idx_s  = reg_index(s_araddr);
        wr_ok_s   = wr_idx_s < ADDR_WIDTH'(NUM_REGS);
        rd_ok_s   = rd_idx_s < ADDR_WIDTH'(NUM_REGS);
    end

    // Read mux; an out-of-range index matches nothing and yields zero.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = (rd_idx_s == ADDR_WIDTH'(i)) ? regs_r[i*DATA_WIDTH +: DATA_WIDTH] : rd_data_s;
        end
    end

    // Reset-release tracker: readies stay low through the first edge after rst drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_done_r <= 1'b0;
        end else begin
            rst_done_r <= 1'b1;
        end
    end

    // AW/W capture; both held flags clear on the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awaddr_r  <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
        end else if (commit_s) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
        end else begin
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                awaddr_r  <= s_awaddr;
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                wdata_r  <= s_wdata;
                wstrb_r  <= s_wstrb;
            end
        end
    end

    // Register bank update with byte strobes; out-of-range commits leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_r <= '0;
        end else if (commit_s && wr_ok_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx_s == ADDR_WIDTH'(i)) begin
                    regs_r[i*DATA_WIDTH +: DATA_WIDTH] <=
                        merge_bytes(regs_r[i*DATA_WIDTH +: DATA_WIDTH], wdata_r, wstrb_r);
                end
            end
        end
    end

    // Write response channel: raised by the commit, held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid_r <= 1'b0;
            bresp_r  <= RESP_OKAY;
        end else if (commit_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_r && s_bready) begin
            bvalid_r <= 1'b0;
        end
    end

    // Read channel: data captured on the AR edge, so a same-edge commit is not visible yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
            rresp_r  <= RESP_OKAY;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_r && s_rready) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
            rresp_r  <= RESP_OKAY;
        end
    end

    assign s_awready = awready_s;
    assign s_wready  = wready_s;
    assign s_arready = arready_s;
    assign s_bvalid  = bvalid_r;
    assign s_bresp   = bresp_r;
    assign s_rvalid  = rvalid_r;
    assign s_rdata   = rdata_r;
    assign s_rresp   = rresp_r;
    assign reg_q     = regs_r;

endmodule

// File: tb/tb_axilite_regfile_slave.sv
// Directed testbench for axilite_regfile_slave: one task per scenario, inline comparisons.
module tb_axilite_regfile_slave;

    logic         clk;
    logic         rst;
    logic [7:0]   s_awaddr;
    logic         s_awvalid;
    logic         s_awready;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic         s_wvalid;
    logic         s_wready;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready;
    logic [7:0]   s_araddr;
    logic         s_arvalid;
    logic         s_arready;
    logic [31:0]  s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rvalid;
    logic         s_rready;
    logic [511:0] reg_q;

    logic [511:0] exp_q;
    int checks;
    int errors;

    axilite_regfile_slave dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_q(reg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All stimulus tasks are entered and left on a falling edge.
    task automatic send_aw(input logic [7:0] addr);
        bit got;
        got = 1'b0;
        s_awaddr = addr; s_awvalid = 1'b1;
        for (int i = 0; i < 32 && !got; i++) begin
            got = s_awready;
            @(negedge clk);
        end
        s_awvalid = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL aw_timeout: awready never seen for addr %h", addr); end
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        bit got;
        got = 1'b0;
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
        for (int i = 0; i < 32 && !got; i++) begin
            got = s_wready;
            @(negedge clk);
        end
        s_wvalid = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL w_timeout: wready never seen for data %h", data); end
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        fork
            send_aw(addr);
            send_w(data, strb);
        join
    endtask

    task automatic wait_b(output logic [1:0] resp);
        bit found;
        found = 1'b0; resp = 2'bxx;
        for (int i = 0; i < 32 && !found; i++) begin
            if (s_bvalid) begin found = 1'b1; resp = s_bresp; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL b_timeout: bvalid never seen"); end
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit got;
        bit found;
        got = 1'b0; found = 1'b0; data = 'x; resp = 2'bxx;
        s_araddr = addr; s_arvalid = 1'b1;
        for (int i = 0; i < 32 && !got; i++) begin
            got = s_arready;
            @(negedge clk);
        end
        s_arvalid = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            if (s_rvalid) begin found = 1'b1; data = s_rdata; resp = s_rresp; end
            @(negedge clk);
        end
        checks++;
        if (!(got && found)) begin errors++; $display("FAIL r_timeout: read of %h got_ar=%0d got_r=%0d", addr, got, found); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin errors++; $display("FAIL reset_readies: got %b expected 000", {s_awready, s_wready, s_arready}); end
        checks++;
        if ({s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata} !== 38'd0) begin errors++; $display("FAIL reset_outputs: bvalid=%b rvalid=%b rdata=%h expected zeros", s_bvalid, s_rvalid, s_rdata); end
        checks++;
        if (reg_q !== exp_q) begin errors++; $display("FAIL reset_regq: got %h expected 0", reg_q); end
        rst = 1'b0;
        #1;
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin errors++; $display("FAIL release_readies: got %b expected 000", {s_awready, s_wready, s_arready}); end
        @(negedge clk);
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++; $display("FAIL ready_after_release: got %b expected 111", {s_awready, s_wready, s_arready}); end
    endtask

    task automatic test_basic;
        logic [1:0]  resp;
        logic [31:0] data;
        do_write(8'h04, 32'hDEADBEEF, 4'hF);
        checks++;
        if (s_bvalid !== 1'b0) begin errors++; $display("FAIL basic_b_early: bvalid got %b expected 0", s_bvalid); end
        @(negedge clk);
        checks++;
        if ({s_bvalid, s_bresp} !== 3'b100) begin errors++; $display("FAIL basic_b_latency: bvalid/bresp got %b expected 100", {s_bvalid, s_bresp}); end
        wait_b(resp);
        exp_q[63:32] = 32'hDEADBEEF;
        checks++;
        if (reg_q !== exp_q) begin errors++; $display("FAIL basic_regq: got %h expected %h", reg_q[63:32], exp_q[63:32]); end
        do_read(8'h04, data, resp);
        checks++;
        if ({data, resp} !== {32'hDEADBEEF, 2'b00}) begin errors++; $display("FAIL basic_read: got %h/%b expected deadbeef/00", data, resp); end
    endtask

    task automatic test_channel_order;
        logic [1:0] resp;
        send_w(32'h11223344, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (s_bvalid !== 1'b0) begin errors++; $display("FAIL w_first_no_b: cycle %0d bvalid got %b expected 0", i, s_bvalid); end
        end
        send_aw(8'h08);
        @(negedge clk);
        checks++;
        if (s_bvalid !== 1'b1) begin errors++; $display("FAIL w_first_b: bvalid got %b expected 1", s_bvalid); end
        wait_b(resp);
        exp_q[95:64] = 32'h11223344;
        checks++;
        if (reg_q !== exp_q) begin errors++; $display("FAIL w_first_regq: reg2 got %h expected 11223344", reg_q[95:64]); end
        send_aw(8'h14);
        repeat (2) @(negedge clk);
        checks++;
        if (s_bvalid !== 1'b0) begin errors++; $display("FAIL aw_first_no_b: bvalid got %b expected 0", s_bvalid); end
        send_w(32'h55667788, 4'hF);
        wait_b(resp);
        exp_q[191:160] = 32'h55667788;
        checks++;
        if ({resp, reg_q} !== {2'b00, exp_q}) begin errors++; $display("FAIL aw_first: resp %b reg5 %h expected 00/55667788", resp, reg_q[191:160]); end
    endtask

    task automatic test_strobe_backpressure;
        logic [1:0] resp;
        do_write(8'h00, 32'hFFFFFFFF, 4'hF);
        wait_b(resp);
        s_bready = 1'b0;
        do_write(8'h00, 32'h00000000, 4'h5);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({s_bvalid, s_bresp, s_awready, s_wready} !== 5'b10000) begin errors++; $display("FAIL bp_hold: cycle %0d bvalid/bresp/awready/wready got %b expected 10000", i, {s_bvalid, s_bresp, s_awready, s_wready}); end
            @(negedge clk);
        end
        exp_q[31:0] = 32'hFF00FF00;
        checks++;
        if (reg_q !== exp_q) begin errors++; $display("FAIL strobe_regq: reg0 got %h expected ff00ff00", reg_q[31:0]); end
        s_bready = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin errors++; $display("FAIL bp_release: bvalid/awready/wready got %b expected 011", {s_bvalid, s_awready, s_wready}); end
        do_write(8'h00, 32'h12345678, 4'h0);
        wait_b(resp);
        checks++;
        if ({resp, reg_q} !== {2'b00, exp_q}) begin errors++; $display("FAIL zero_strobe: resp %b reg0 %h expected 00/ff00ff00", resp, reg_q[31:0]); end
    endtask

    task automatic test_out_of_range;
        logic [1:0]  resp;
        logic [31:0] data;
        do_write(8'h40, 32'hCAFEF00D, 4'hF);
        wait_b(resp);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %b expected 10", resp); end
        checks++;
        if (reg_q !== exp_q) begin errors++; $display("FAIL oor_regq: got %h expected %h", reg_q, exp_q); end
        do_read(8'h40, data, resp);
        checks++;
        if ({data, resp} !== {32'h0, 2'b10}) begin errors++; $display("FAIL oor_read: got %h/%b expected 0/10", data, resp); end
    endtask

    task automatic test_collision;
        logic [1:0]  resp;
        logic [31:0] data;
        do_write(8'h0C, 32'h0000000A, 4'hF);
        wait_b(resp);
        exp_q[127:96] = 32'h0000000A;
        do_write(8'h0C, 32'h0000000B, 4'hF);
        // AR handshakes on the commit edge of the write just issued
        s_araddr = 8'h0C; s_arvalid = 1'b1;
        checks++;
        if (s_arready !== 1'b1) begin errors++; $display("FAIL coll_arready: got %b expected 1", s_arready); end
        @(negedge clk);
        s_arvalid = 1'b0;
        checks++;
        if ({s_rvalid, s_rdata, s_bvalid} !== {1'b1, 32'h0000000A, 1'b1}) begin errors++; $display("FAIL coll_old_value: rvalid %b rdata %h bvalid %b expected 1/0000000a/1", s_rvalid, s_rdata, s_bvalid); end
        @(negedge clk);
        exp_q[127:96] = 32'h0000000B;
        do_read(8'h0C, data, resp);
        checks++;
        if ({data, resp, reg_q} !== {32'h0000000B, 2'b00, exp_q}) begin errors++; $display("FAIL coll_new_value: got %h/%b expected 0000000b/00", data, resp); end
    endtask

    task automatic test_back_to_back;
        s_araddr = 8'h04; s_arvalid = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_rvalid, s_arready, s_rdata} !== {2'b10, 32'hDEADBEEF}) begin errors++; $display("FAIL b2b_first: rvalid/arready %b rdata %h expected 10/deadbeef", {s_rvalid, s_arready}, s_rdata); end
        @(negedge clk);
        checks++;
        if ({s_rvalid, s_arready} !== 2'b01) begin errors++; $display("FAIL b2b_gap: rvalid/arready got %b expected 01", {s_rvalid, s_arready}); end
        s_araddr = 8'h08;
        @(negedge clk);
        s_arvalid = 1'b0;
        checks++;
        if ({s_rvalid, s_rdata} !== {1'b1, 32'h11223344}) begin errors++; $display("FAIL b2b_second: rvalid %b rdata %h expected 1/11223344", s_rvalid, s_rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        send_aw(8'h10);
        s_rready = 1'b0;
        s_araddr = 8'h00; s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        checks++;
        if (s_rvalid !== 1'b1) begin errors++; $display("FAIL mid_rvalid_pending: got %b expected 1", s_rvalid); end
        rst = 1'b1;
        #1;
        exp_q = '0;
        checks++;
        if ({s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 5'b00000) begin errors++; $display("FAIL mid_reset_outputs: got %b expected 00000", {s_bvalid, s_rvalid, s_awready, s_wready, s_arready}); end
        checks++;
        if (reg_q !== exp_q) begin errors++; $display("FAIL mid_reset_regq: got %h expected 0", reg_q); end
        @(negedge clk);
        rst = 1'b0;
        s_rready = 1'b1;
        #1;
        checks++;
        if (s_awready !== 1'b0) begin errors++; $display("FAIL mid_release_ready: got %b expected 0", s_awready); end
        @(negedge clk);
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++; $display("FAIL mid_ready_back: got %b expected 111", {s_awready, s_wready, s_arready}); end
        send_w(32'h00000099, 4'hF);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({s_bvalid, s_rvalid, s_wready} !== 3'b000) begin errors++; $display("FAIL mid_no_completion: cycle %0d bvalid/rvalid/wready got %b expected 000", i, {s_bvalid, s_rvalid, s_wready}); end
            @(negedge clk);
        end
        checks++;
        if (reg_q !== exp_q) begin errors++; $display("FAIL mid_regq_after: got %h expected 0", reg_q); end
    endtask

    initial begin
        checks = 0; errors = 0;
        exp_q = '0;
        rst = 1'b1;
        s_awaddr = 8'h00; s_awvalid = 1'b0;
        s_wdata = 32'h0; s_wstrb = 4'h0; s_wvalid = 1'b0;
        s_bready = 1'b1;
        s_araddr = 8'h00; s_arvalid = 1'b0;
        s_rready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_channel_order();
        test_strobe_backpressure();
        test_out_of_range();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axilite_regfile_slave.md
Name: axilite_regfile_slave

Overview:
- Synthesizable AXI-Lite responder (slave) backed by a bank of NUM_REGS read/write registers.
- It is the DUT-side counterpart of the team's AXI-Lite initiator agent. It terminates the five AXI-Lite channels and exposes register contents as a flat output for downstream logic.
- Read and write paths are independent and allow one outstanding transaction each.

Parameters:
- ADDR_WIDTH, 8, byte-address width of AW/AR channels.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- NUM_REGS, 16, number of registers; NUM_REGS*DATA_WIDTH/8 <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock; all logic samples on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_awaddr  in  ADDR_WIDTH  write address.
- s_awvalid  in  1  write address valid.
- s_awready  out  1  write address ready.
- s_wdata  in  DATA_WIDTH  write data.
- s_wstrb  in  DATA_WIDTH/8  byte strobes.
- s_wvalid  in  1  write data valid.
- s_wready  out  1  write data ready.
- s_bresp  out  2  write response.
- s_bvalid  out  1  write response valid.
- s_bready  in  1  write response ready.
- s_araddr  in  ADDR_WIDTH  read address.
- s_arvalid  in  1  read address valid.
- s_arready  out  1  read address ready.
- s_rdata  out  DATA_WIDTH  read data.
- s_rresp  out  2  read response.
- s_rvalid  out  1  read data valid.
- s_rready  in  1  read data ready.
- reg_q  out  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (async assert, sync release):
  - All registers, reg_q, s_bvalid, s_rvalid, s_rdata, s_bresp and s_rresp go to 0.
  - Held AW/W state is cleared.
  - Internal rst_done flag goes to 0.
  - All readies are 0 while rst is high and for the first edge after release; rst_done sets on that edge.
  - Reset mid-transaction discards any captured address/data and any pending B or R response, with no completion.
- Decode:
  - Register index = addr >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
  - Address is valid iff index < NUM_REGS.
  - Responses: OKAY = 2'b00, SLVERR = 2'b10.
- Write path, AW and W accepted independently in any order:
  - s_awready = rst_done & !aw_held & !s_bvalid.
  - s_wready = rst_done & !w_held & !s_bvalid.
  - On AW handshake: latch address, set aw_held.
  - On W handshake: latch data and strobe, set w_held.
  - AW and W may handshake in the same cycle.
- Write commit:
  - On the first edge where aw_held & w_held are both registered high, update the register bytes whose strobe bit is 1, set s_bvalid = 1, and clear both held flags.
  - Latency: s_bvalid is high 2 cycles after the later of the two handshake cycles.
  - Invalid address: no register changes, s_bresp = SLVERR.
  - All-zero strobe: no change, OKAY.
- Write response: s_bvalid and s_bresp hold until s_bvalid & s_bready. No new AW or W is accepted while s_bvalid = 1.
- Read path:
  - s_arready = rst_done & !s_rvalid.
  - On AR handshake at edge k: s_rdata and s_rresp are registered at edge k and s_rvalid = 1 from that edge.
  - Invalid address: s_rdata = 0, s_rresp = SLVERR.
  - s_rvalid, s_rdata and s_rresp are stable until s_rready; they clear on the handshake edge.
  - Back-to-back reads: a new AR is accepted no earlier than the cycle after the R handshake.
- Read/write collision: an AR handshake on the same edge as a commit to the same register returns the pre-write value.
- reg_q reflects register state directly (registered outputs, no extra latency).
- Stability: outputs never depend combinationally on any *valid input, so no combinational valid-to-ready path exists.

Test Plan:
- Basic write then read: AW = 0x04 and W = 0xDEADBEEF (strb 0xF) in the same cycle, then AR 0x04 -> BRESP OKAY two cycles after the handshake; reg_q[63:32] = 0xDEADBEEF; RDATA = 0xDEADBEEF with RRESP OKAY.
- Channel order: W (0x11223344) issued 3 cycles before AW (0x08) -> B only after AW completes; reg 2 = 0x11223344. Also cover AW issued before W.
- Strobe and backpressure: reg 0 = 0xFFFFFFFF, write 0x00000000 with strb 0x5, hold s_bready = 0 for 4 cycles -> reg 0 = 0xFF00FF00; BVALID is held and AWREADY/WREADY stay 0 until the B handshake.
- Out of range: write to 0x40 with NUM_REGS = 16, then read 0x40 -> BRESP = 2'b10 with no reg_q change; RDATA = 0 with RRESP = 2'b10.
- Collision: reg 3 = 0xA, write 0xB to 0x0C committing on the same edge as an AR to 0x0C -> RDATA = 0xA; a following read returns 0xB.
- Reset mid-operation: assert rst with AW held and RVALID pending -> next cycle all valids and reg_q are 0; readies return one cycle after release; no B or R is ever issued for the dropped transactions.
